// File: rtl/prim_clock_mux2_sel_ctrl.sv
// prim_clock_mux2_sel_ctrl: gates the clock, flips the 2:1 mux select, lets it settle, then ungates and acks.
module prim_clock_mux2_sel_ctrl #(
    parameter int unsigned GateCycles   = 4,
    parameter int unsigned SettleCycles = 8,
    parameter logic        ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_valid_i,
    input  logic req_sel_i,
    output logic req_ready_o,
    output logic sel_o,
    output logic gate_en_o,
    output logic busy_o,
    output logic ack_o
);
    localparam int unsigned MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] GateLoad = CntW'(GateCycles - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

    if (GateCycles < 1 || GateCycles > 255) begin : g_bad_gate
        $error("GateCycles must be in 1..255");
    end
    if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle
        $error("SettleCycles must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, WAIT_GATE, WAIT_SETTLE, ACK} state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic sel_q, sel_d, gate_q, gate_d, ack_q, ack_d, tgt_q, tgt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= ResetSel;
            gate_q  <= 1'b1;
            ack_q   <= 1'b0;
            tgt_q   <= ResetSel;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            ack_q   <= ack_d;
            tgt_q   <= tgt_d;
        end
    end

    // The select only moves in WAIT_GATE, where the gate is guaranteed off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gate_d  = gate_q;
        ack_d   = 1'b0;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    tgt_d = req_sel_i;
                    if (req_sel_i == sel_q) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = WAIT_GATE;
                        gate_d  = 1'b0;
                        cnt_d   = GateLoad;
                    end
                end
            end
            WAIT_GATE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    sel_d   = tgt_q;
                    cnt_d   = SettleLoad;
                    state_d = WAIT_SETTLE;
                end
            end
            WAIT_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    gate_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign sel_o       = sel_q;
    assign gate_en_o   = gate_q;
    assign ack_o       = ack_q;
endmodule

// File: tb/tb_prim_clock_mux2_sel_ctrl.sv
// tb_prim_clock_mux2_sel_ctrl: directed checks of the default and the minimal (1,1) sequencer.
module tb_prim_clock_mux2_sel_ctrl;
    logic clk, rst_n;
    logic v0, s0, rdy0, sel0, gate0, busy0, ack0;
    logic v1, s1, rdy1, sel1, gate1, busy1, ack1;
    logic prev0, prev1;
    int total, bad;

    prim_clock_mux2_sel_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v0), .req_sel_i(s0),
        .req_ready_o(rdy0), .sel_o(sel0), .gate_en_o(gate0), .busy_o(busy0), .ack_o(ack0)
    );

    prim_clock_mux2_sel_ctrl #(.GateCycles(1), .SettleCycles(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v1), .req_sel_i(s1),
        .req_ready_o(rdy1), .sel_o(sel1), .gate_en_o(gate1), .busy_o(busy1), .ack_o(ack1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the structural invariants of both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (sel0 !== prev0) chk("sel0_moved_ungated", {7'd0, gate0}, 8'd0);
            if (sel1 !== prev1) chk("sel1_moved_ungated", {7'd0, gate1}, 8'd0);
            if (!gate0) chk("gate0_off_not_busy", {7'd0, busy0}, 8'd1);
            if (!gate1) chk("gate1_off_not_busy", {7'd0, busy1}, 8'd1);
            if (ack0) chk("ack0_with_ready", {7'd0, rdy0}, 8'd0);
            if (ack1) chk("ack1_with_ready", {7'd0, rdy1}, 8'd0);
        end
        prev0 = sel0;
        prev1 = sel1;
    endtask

    // Full default switch (4,8): {sel,gate,ack,ready} over cycles k+1..k+14.
    task automatic do_switch(input logic ns);
        v0 = 1'b1;
        s0 = ns;
        tick();
        v0 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("sw%0b_c%0d", ns, c), {4'd0, sel0, gate0, ack0, rdy0},
                {4'd0, (c >= 5) ? ns : ~ns, c > 12, c == 13, c >= 14});
            if (c < 14) tick();
        end
    endtask

    initial begin
        int accepts, acks, second_at, ack_a, ack_b;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        v0 = 1'b0; s0 = 1'b0; v1 = 1'b0; s1 = 1'b0;
        prev0 = 1'b0; prev1 = 1'b0;
        repeat (3) tick();
        chk("rst0", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1100);
        chk("rst1", {3'd0, sel1, gate1, rdy1, busy1, ack1}, 8'b0000_1100);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d", i), {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1100);
        end

        v0 = 1'b1;
        s0 = 1'b0;
        tick();
        v0 = 1'b0;
        chk("same_k1", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1011);
        tick();
        chk("same_k2", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1100);

        do_switch(1'b1);
        tick();
        chk("post_sw_idle", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0001_1100);

        // Held valid with toggling select: only the first IDLE cycle may accept again.
        accepts = 0; acks = 0; second_at = -1; ack_a = -1; ack_b = -1;
        v0 = 1'b1;
        s0 = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (ack0) begin
                acks++;
                if (acks == 1) ack_a = c; else ack_b = c;
            end
            if (rdy0 && v0) begin
                accepts++;
                if (accepts == 2) second_at = c;
            end
            tick();
            if (accepts == 2) v0 = 1'b0; else s0 = ~s0;
        end
        chk("hold_accepts", 8'(accepts), 8'd2);
        chk("hold_second_at", 8'(second_at), 8'd14);
        chk("hold_acks", 8'(acks), 8'd2);
        chk("hold_ack_a", 8'(ack_a), 8'd13);
        chk("hold_ack_b", 8'(ack_b), 8'd15);
        chk("hold_end", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1100);

        v0 = 1'b1;
        s0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (6) tick();
        chk("settle_pre_rst", {6'd0, sel0, gate0}, 8'b0000_0010);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst0", {3'd0, sel0, gate0, rdy0, busy0, ack0}, 8'b0000_1100);
        chk("async_rst1", {3'd0, sel1, gate1, rdy1, busy1, ack1}, 8'b0000_1100);
        #2 rst_n = 1'b1;
        prev0 = sel0;
        prev1 = sel1;
        tick();
        do_switch(1'b1);

        v1 = 1'b1;
        s1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("min_c%0d", c), {4'd0, sel1, gate1, ack1, rdy1},
                {4'd0, c >= 2, c > 2, c == 3, c >= 4});
            if (c < 4) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
